// File: rtl/stopwatch_display_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_display_counter
//
// Purpose:
//   Time-keeping and display stage of the stopwatch. Holds an MM:SS time as
//   four BCD digits and advances it on the 1 Hz tick while counting is
//   enabled. Drives the four 7-segment digits with registered, active-low
//   segment patterns. While paused, the display can optionally blink.
//
// Parameters:
//   MAX_MINUTES  last minute value before the time wraps to 00:00 (1..99)
//   BLINK_EN     1: the display toggles blank/visible on each tick while paused
//                0: the display stays steady while paused
//
// Ports:
//   clk          system clock (CLOCK_50 domain), rising edge only
//   rst_n        asynchronous active-low reset
//   tick         one-cycle 1 Hz strobe, synchronous to clk
//   counting     level from the FSM: time advances on tick
//   reset_timer  level from the FSM: clears the time to 00:00 (top priority)
//   rollover     one-cycle pulse after the time wraps MAX_MINUTES:59 -> 00:00
//   HEX0..HEX3   seconds ones, seconds tens, minutes ones, minutes tens;
//                active-low, bit0 = segment a .. bit6 = segment g
//
// Timing:
//   Digits, blink phase and rollover update on the edge that samples the
//   inputs. HEX outputs are registered from those values one edge later.
// -----------------------------------------------------------------------------
module stopwatch_display_counter #(
  parameter int MAX_MINUTES = 59,
  parameter bit BLINK_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       counting,
  input  logic       reset_timer,
  output logic       rollover,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);

  localparam logic [3:0] MAX_M10 = 4'(MAX_MINUTES / 10);
  localparam logic [3:0] MAX_M1  = 4'(MAX_MINUTES % 10);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  // Time digits and blink phase.
  logic [3:0] s1, s10, m1, m10;
  logic       blink;

  logic [3:0] s1_nxt, s10_nxt, m1_nxt, m10_nxt;
  logic       blink_nxt;
  logic       rollover_nxt;
  logic       at_max;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  assign at_max = (m10 == MAX_M10) && (m1 == MAX_M1) &&
                  (s10 == 4'd5) && (s1 == 4'd9);

  // Next-state selection, highest priority first: clear, count, pause-tick,
  // then hold. rollover is a pulse, so it defaults low every cycle.
  always_comb begin
    s1_nxt       = s1;
    s10_nxt      = s10;
    m1_nxt       = m1;
    m10_nxt      = m10;
    blink_nxt    = blink;
    rollover_nxt = 1'b0;

    if (reset_timer) begin
      s1_nxt    = 4'd0;
      s10_nxt   = 4'd0;
      m1_nxt    = 4'd0;
      m10_nxt   = 4'd0;
      blink_nxt = 1'b0;
    end else if (tick && counting) begin
      blink_nxt = 1'b0;
      if (at_max) begin
        s1_nxt       = 4'd0;
        s10_nxt      = 4'd0;
        m1_nxt       = 4'd0;
        m10_nxt      = 4'd0;
        rollover_nxt = 1'b1;
      end else if (s1 != 4'd9) begin
        s1_nxt = s1 + 4'd1;
      end else begin
        s1_nxt = 4'd0;
        if (s10 != 4'd5) begin
          s10_nxt = s10 + 4'd1;
        end else begin
          s10_nxt = 4'd0;
          if (m1 != 4'd9) begin
            m1_nxt = m1 + 4'd1;
          end else begin
            m1_nxt  = 4'd0;
            m10_nxt = m10 + 4'd1;
          end
        end
      end
    end else if (tick) begin
      if (BLINK_EN) begin
        blink_nxt = ~blink;
      end else begin
        blink_nxt = 1'b0;
      end
    end else if (counting) begin
      // Resuming without a tick must show a steady display immediately.
      blink_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 4'd0;
      s10      <= 4'd0;
      m1       <= 4'd0;
      m10      <= 4'd0;
      blink    <= 1'b0;
      rollover <= 1'b0;
    end else begin
      s1       <= s1_nxt;
      s10      <= s10_nxt;
      m1       <= m1_nxt;
      m10      <= m10_nxt;
      blink    <= blink_nxt;
      rollover <= rollover_nxt;
    end
  end

  // Display registers sample the current digits, giving one cycle of latency
  // behind the digit update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HEX0 <= SEG_ZERO;
      HEX1 <= SEG_ZERO;
      HEX2 <= SEG_ZERO;
      HEX3 <= SEG_ZERO;
    end else if (blink) begin
      HEX0 <= SEG_BLANK;
      HEX1 <= SEG_BLANK;
      HEX2 <= SEG_BLANK;
      HEX3 <= SEG_BLANK;
    end else begin
      HEX0 <= seg_encode(s1);
      HEX1 <= seg_encode(s10);
      HEX2 <= seg_encode(m1);
      HEX3 <= seg_encode(m10);
    end
  end

endmodule

// File: tb/tb_stopwatch_display_counter.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_display_counter
//
// Three instances share one stimulus stream:
//   dut 0: MAX_MINUTES=59, BLINK_EN=1
//   dut 1: MAX_MINUTES=5,  BLINK_EN=1
//   dut 2: MAX_MINUTES=59, BLINK_EN=0
// A model tracks each instance's time as a plain count of seconds and derives
// the expected digits and segments from it. A compare process checks every
// instance against the model on every falling edge; directed literal checks
// pin the model at the interesting points.
// -----------------------------------------------------------------------------
module tb_stopwatch_display_counter;

  localparam int N_DUT = 3;
  localparam int MAXM [N_DUT] = '{59, 5, 59};
  localparam bit BLNK [N_DUT] = '{1'b1, 1'b1, 1'b0};

  // ---------------- clock / reset ----------------
  logic clk;
  logic clk_run;
  logic rst_n;
  logic tick;
  logic counting;
  logic reset_timer;
  logic chk_en;

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  // ---------------- DUTs ----------------
  logic [3:0][6:0] hex_d [N_DUT];
  logic            roll_d [N_DUT];

  stopwatch_display_counter #(.MAX_MINUTES(59), .BLINK_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .counting(counting),
    .reset_timer(reset_timer), .rollover(roll_d[0]),
    .HEX0(hex_d[0][0]), .HEX1(hex_d[0][1]), .HEX2(hex_d[0][2]), .HEX3(hex_d[0][3])
  );

  stopwatch_display_counter #(.MAX_MINUTES(5), .BLINK_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .counting(counting),
    .reset_timer(reset_timer), .rollover(roll_d[1]),
    .HEX0(hex_d[1][0]), .HEX1(hex_d[1][1]), .HEX2(hex_d[1][2]), .HEX3(hex_d[1][3])
  );

  stopwatch_display_counter #(.MAX_MINUTES(59), .BLINK_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .counting(counting),
    .reset_timer(reset_timer), .rollover(roll_d[2]),
    .HEX0(hex_d[2][0]), .HEX1(hex_d[2][1]), .HEX2(hex_d[2][2]), .HEX3(hex_d[2][3])
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total;
  int bad;

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] seg_tab [10];
  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24;
    seg_tab[3] = 7'h30; seg_tab[4] = 7'h19; seg_tab[5] = 7'h12;
    seg_tab[6] = 7'h02; seg_tab[7] = 7'h78; seg_tab[8] = 7'h00;
    seg_tab[9] = 7'h10;
  end

  // Digit k (0=seconds ones .. 3=minutes tens) of a time given in seconds.
  function automatic int digit_of(input int secs, input int k);
    int s;
    int m;
    s = secs % 60;
    m = secs / 60;
    case (k)
      0:       return s % 10;
      1:       return s / 10;
      2:       return m % 10;
      default: return m / 10;
    endcase
  endfunction

  int         m_secs  [N_DUT];
  bit         m_blink [N_DUT];
  bit         m_roll  [N_DUT];
  logic [6:0] m_hex   [N_DUT][4];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N_DUT; i++) begin
      if (!rst_n) begin
        m_secs[i]  <= 0;
        m_blink[i] <= 1'b0;
        m_roll[i]  <= 1'b0;
        for (int k = 0; k < 4; k++) m_hex[i][k] <= 7'h40;
      end else begin
        // Display reflects the time and phase as they stood before this edge.
        for (int k = 0; k < 4; k++)
          m_hex[i][k] <= m_blink[i] ? 7'h7F : seg_tab[digit_of(m_secs[i], k)];
        m_roll[i] <= 1'b0;
        if (reset_timer) begin
          m_secs[i]  <= 0;
          m_blink[i] <= 1'b0;
        end else if (tick && counting) begin
          m_blink[i] <= 1'b0;
          if (m_secs[i] == MAXM[i] * 60 + 59) begin
            m_secs[i] <= 0;
            m_roll[i] <= 1'b1;
          end else begin
            m_secs[i] <= m_secs[i] + 1;
          end
        end else if (tick) begin
          m_blink[i] <= BLNK[i] ? ~m_blink[i] : 1'b0;
        end else if (counting) begin
          m_blink[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N_DUT; i++) begin
        check($sformatf("cyc_roll[%0d]", i), int'(roll_d[i]), int'(m_roll[i]));
        for (int k = 0; k < 4; k++)
          check($sformatf("cyc_hex%0d[%0d]", k, i), int'(hex_d[i][k]), int'(m_hex[i][k]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Single tick; returns on the falling edge after the edge that sampled it.
  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  // n back-to-back ticks; returns like pulse_tick.
  task automatic run_ticks(input int n);
    @(negedge clk) tick = 1'b1;
    repeat (n - 1) @(negedge clk);
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic clear_time();
    @(negedge clk) reset_timer = 1'b1;
    @(negedge clk) reset_timer = 1'b0;
  endtask

  task automatic check_hex(input string name, input int i,
                           input logic [6:0] h3, input logic [6:0] h2,
                           input logic [6:0] h1, input logic [6:0] h0);
    check($sformatf("%s_hex3[%0d]", name, i), int'(hex_d[i][3]), int'(h3));
    check($sformatf("%s_hex2[%0d]", name, i), int'(hex_d[i][2]), int'(h2));
    check($sformatf("%s_hex1[%0d]", name, i), int'(hex_d[i][1]), int'(h1));
    check($sformatf("%s_hex0[%0d]", name, i), int'(hex_d[i][0]), int'(h0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    total       = 0;
    bad         = 0;
    chk_en      = 1'b0;
    clk_run     = 1'b0;
    rst_n       = 1'b1;
    tick        = 1'b0;
    counting    = 1'b0;
    reset_timer = 1'b0;

    // Reset with the clock stopped: outputs must settle without any edge.
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      check_hex("rst_async", i, 7'h40, 7'h40, 7'h40, 7'h40);
      check($sformatf("rst_async_roll[%0d]", i), int'(roll_d[i]), 0);
    end
    chk_en  = 1'b1;
    clk_run = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      check_hex("idle", i, 7'h40, 7'h40, 7'h40, 7'h40);
      check($sformatf("idle_roll[%0d]", i), int'(roll_d[i]), 0);
    end

    // 75 ticks, 5 cycles apart -> 01:15 on every instance.
    counting = 1'b1;
    for (int t = 0; t < 75; t++) begin
      if (t > 0) repeat (3) @(negedge clk);
      pulse_tick();
    end
    @(negedge clk);
    for (int i = 0; i < N_DUT; i++)
      check_hex("cnt75", i, 7'h40, 7'h79, 7'h79, 7'h12);

    // Wrap: 3598 ticks -> 59:58 (dut1: 05:58), then two more.
    clear_time();
    run_ticks(3598);
    @(negedge clk);
    check_hex("pre_wrap", 0, 7'h12, 7'h10, 7'h12, 7'h00);
    check_hex("pre_wrap", 1, 7'h40, 7'h12, 7'h12, 7'h00);
    pulse_tick();
    check("wrap59_roll_early", int'(roll_d[0]), 0);
    @(negedge clk);
    check_hex("at_5959", 0, 7'h12, 7'h10, 7'h12, 7'h10);
    check_hex("at_0559", 1, 7'h40, 7'h12, 7'h12, 7'h10);
    pulse_tick();
    for (int i = 0; i < N_DUT; i++)
      check($sformatf("wrap_roll_hi[%0d]", i), int'(roll_d[i]), 1);
    @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("wrap_roll_lo[%0d]", i), int'(roll_d[i]), 0);
      check_hex("wrapped", i, 7'h40, 7'h40, 7'h40, 7'h40);
    end

    // Pause and blink at 00:07.
    clear_time();
    run_ticks(7);
    @(negedge clk) counting = 1'b0;
    pulse_tick();
    @(negedge clk);
    check_hex("blink1", 0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    check_hex("blink1", 1, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    check_hex("steady1", 2, 7'h40, 7'h40, 7'h40, 7'h78);
    pulse_tick();
    @(negedge clk);
    for (int i = 0; i < N_DUT; i++)
      check_hex("blink2", i, 7'h40, 7'h40, 7'h40, 7'h78);
    pulse_tick();
    @(negedge clk);
    check_hex("blink3", 0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    check_hex("steady3", 2, 7'h40, 7'h40, 7'h40, 7'h78);
    counting = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N_DUT; i++)
      check_hex("resume", i, 7'h40, 7'h40, 7'h40, 7'h78);
    pulse_tick();
    @(negedge clk);
    for (int i = 0; i < N_DUT; i++)
      check_hex("resume_cnt", i, 7'h40, 7'h40, 7'h40, 7'h00);

    // reset_timer together with tick at 00:42.
    clear_time();
    run_ticks(42);
    @(negedge clk);
    check_hex("at_0042", 0, 7'h40, 7'h40, 7'h19, 7'h24);
    reset_timer = 1'b1;
    tick        = 1'b1;
    @(negedge clk);
    reset_timer = 1'b0;
    tick        = 1'b0;
    check("simul42_roll", int'(roll_d[0]), 0);
    @(negedge clk);
    for (int i = 0; i < N_DUT; i++)
      check_hex("simul42", i, 7'h40, 7'h40, 7'h40, 7'h40);

    // reset_timer together with tick at 59:59 (dut1 at 05:59): no rollover.
    clear_time();
    run_ticks(3599);
    @(negedge clk);
    check_hex("at_5959b", 0, 7'h12, 7'h10, 7'h12, 7'h10);
    reset_timer = 1'b1;
    tick        = 1'b1;
    @(negedge clk);
    reset_timer = 1'b0;
    tick        = 1'b0;
    for (int i = 0; i < N_DUT; i++)
      check($sformatf("simul5959_roll[%0d]", i), int'(roll_d[i]), 0);
    @(negedge clk);
    for (int i = 0; i < N_DUT; i++)
      check_hex("simul5959", i, 7'h40, 7'h40, 7'h40, 7'h40);

    // Short rst_n pulse between edges at 12:34.
    clear_time();
    run_ticks(754);
    @(negedge clk);
    check_hex("at_1234", 0, 7'h79, 7'h24, 7'h30, 7'h19);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      check_hex("rst_mid", i, 7'h40, 7'h40, 7'h40, 7'h40);
      check($sformatf("rst_mid_roll[%0d]", i), int'(roll_d[i]), 0);
    end
    #1 rst_n = 1'b1;
    pulse_tick();
    @(negedge clk);
    for (int i = 0; i < N_DUT; i++)
      check_hex("after_rst", i, 7'h40, 7'h40, 7'h40, 7'h79);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_display_counter.md
# stopwatch_display_counter

Stopwatch time-keeping and display stage that consumes the FSM's `counting` and `reset_timer` outputs and drives the four DE10-Lite 7-segment digits HEX0..HEX3. It keeps an MM:SS time in four BCD digit registers and advances it on a one-cycle 1 Hz `tick` strobe while counting is enabled. It encodes each digit to active-low segment patterns into registered outputs. While paused, it optionally blinks the display.

## Interface
Parameters:
- `MAX_MINUTES`, default 59: last minute value before wrap to 00:00. Legal range 1..99, two-digit decimal.
- `BLINK_EN`, default 1: 1 blanks and unblanks the display on each tick while paused; 0 shows a steady display.

Ports:
- `clk`  input  1  single system clock, CLOCK_50 domain. All logic is on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `tick`  input  1  one-`clk`-cycle strobe at 1 Hz, synchronous to `clk`.
- `counting`  input  1  level from the FSM. 1 means time advances on `tick`.
- `reset_timer`  input  1  level from the FSM. 1 clears the time to 00:00.
- `rollover`  output  1  one-cycle pulse when the time wraps from MAX_MINUTES:59 to 00:00.
- `HEX0`  output  7  seconds ones, active-low, bit0=a .. bit6=g.
- `HEX1`  output  7  seconds tens.
- `HEX2`  output  7  minutes ones.
- `HEX3`  output  7  minutes tens.

## Operation
- State: `s1` (0..9), `s10` (0..5), `m1` (0..9), `m10` (0..9), each 4-bit BCD. `blink` is a 1-bit phase register.
- Priority per cycle, highest first:
  - `reset_timer`=1: all digits cleared to 0, `blink` cleared to 0, no `rollover`. This happens regardless of `tick` or `counting`.
  - `tick`=1 and `counting`=1: increment the time, `blink` cleared to 0.
  - `tick`=1 and `counting`=0: time held. `blink` toggles if BLINK_EN=1, otherwise it stays 0.
  - Otherwise: everything held.
- Increment rules:
  - `s1` 9→0 carries into `s10`.
  - `s10` 5→0 carries into `m1`.
  - `m1` 9→0 carries into `m10`.
  - When the time equals MAX_MINUTES:59 (`m10`:`m1` = MAX_MINUTES/10 : MAX_MINUTES%10, `s10`=5, `s1`=9), the next value is 00:00. In that same update `rollover`=1 for exactly one cycle.
  - No other path sets `rollover`.
- `counting`=1 with `tick`=0 forces `blink` to 0 on that cycle.
- Segment encoding, active-low, hex values:
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - Any non-BCD value (unreachable) encodes to 7F, blank.
- Display:
  - When `blink`=1, all HEX outputs are 7F.
  - Otherwise each HEX shows the encoding of its digit.
  - No leading-zero suppression.

## Timing
- Reset (`rst_n`=0, asynchronous, effective immediately without a clock):
  - digits 0, `blink`=0, `rollover`=0.
  - HEX0..HEX3 = 40 ("00:00").
- Deassertion of `rst_n` is assumed synchronized upstream. The first edge after release operates normally.
- Latency:
  - Inputs are sampled at rising edge N.
  - Digit registers and `rollover` update at edge N.
  - HEX registers update from the new digits and `blink` at edge N+1, i.e. one cycle of display latency.
- `rollover` is registered. It is high for the cycle following edge N when edge N performed the wrap.
- `tick` longer than one cycle is outside specification. Each high cycle counts as a separate tick.
- An `rst_n` assertion mid-count discards the current time immediately. No partial carry is retained.
- `counting` and `reset_timer` are level inputs, sampled only at edges. There is no edge detection in this block.

## Test plan
- Reset: hold `rst_n`=0 with `clk` stopped → HEX3..HEX0 = 40,40,40,40 and `rollover`=0 immediately, with no clock edge. Release, idle 10 cycles → unchanged.
- Counting: `counting`=1, apply 75 ticks spaced 5 cycles apart → time reads 01:15. HEX3..HEX0 = 40,79,79,12, valid one cycle after the last tick.
- Wrap: preload by ticking to 59:58 (MAX_MINUTES=59), then apply 2 ticks → 59:59, then 00:00 with `rollover` high exactly one cycle. Also check MAX_MINUTES=5: after 05:59 → 00:00 with `rollover`.
- Pause and blink: at 00:07, `counting`=0, apply 3 ticks → HEX all 7F, then 7F-free 00:07, then 7F again. Time stays 00:07. Set `counting`=1 → display steady, counting resumes. With BLINK_EN=0 the display is steady throughout the pause.
- Simultaneous events: at 00:42, assert `reset_timer` and `tick` in the same cycle with `counting`=1 → 00:00, `rollover`=0, `blink`=0. At 59:59, do the same → 00:00 with no `rollover` pulse.
- Reset mid-operation: while counting at 12:34, pulse `rst_n` low between edges for less than one cycle → immediate 00:00 display of 40s. The next tick after release gives 00:01.
